// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern constants, bus layout and digit count.
// The same constants serve the encoder (segment_display) and the scan decoder.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef struct packed {
        logic       dp;
        logic [6:0] gfedcba;
    } seg_bus_t;

endpackage

// File: rtl/segment_scan_decoder_if.sv
// Scanned display bus plus the recovered-frame outputs of the scan decoder.
interface segment_scan_decoder_if;
    import seg7_pkg::*;

    logic [NUM_DIGITS-1:0]      an;
    seg_bus_t                   seg;
    logic [NUM_DIGITS*4-1:0]    digits;
    logic [NUM_DIGITS-1:0]      dpout;
    logic [NUM_DIGITS-1:0]      en_out;
    logic                       frame_valid;
    logic                       code_err;
    logic                       an_err;

    modport master (
        output an, seg,
        input  digits, dpout, en_out, frame_valid, code_err, an_err
    );

    modport slave (
        input  an, seg,
        output digits, dpout, en_out, frame_valid, code_err, an_err
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; hit=0 for unknown patterns.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nib,
    output logic       hit
);

    always_comb begin
        nib = 4'h0;
        hit = 1'b1;
        case (pat)
            SEG_0: nib = 4'h0;
            SEG_1: nib = 4'h1;
            SEG_2: nib = 4'h2;
            SEG_3: nib = 4'h3;
            SEG_4: nib = 4'h4;
            SEG_5: nib = 4'h5;
            SEG_6: nib = 4'h6;
            SEG_7: nib = 4'h7;
            SEG_8: nib = 4'h8;
            SEG_9: nib = 4'h9;
            SEG_A: nib = 4'hA;
            SEG_B: nib = 4'hB;
            SEG_C: nib = 4'hC;
            SEG_D: nib = 4'hD;
            SEG_E: nib = 4'hE;
            SEG_F: nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/segment_scan_decoder.sv
// Samples a multiplexed 4-digit seven-segment bus and publishes one coherent
// frame per scan cycle, committed on index wrap or after a run of idle slots.
module segment_scan_decoder
    import seg7_pkg::*;
#(
    parameter int IDLE_LIMIT = 8
) (
    input  logic                   clk_1kHz,
    input  logic                   rst,
    segment_scan_decoder_if.slave  bus
);

    localparam int CW = $clog2(IDLE_LIMIT + 1);

    logic [NUM_DIGITS-1:0]      an_q;
    seg_bus_t                   seg_q;

    logic [NUM_DIGITS-1:0][3:0] sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]      sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]      seen_q, seen_d;
    logic [1:0]                 last_k_q, last_k_d;
    logic [CW-1:0]              idle_cnt_q, idle_cnt_d;

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      dpout_q, dpout_d;
    logic [NUM_DIGITS-1:0]      en_out_q, en_out_d;
    logic                       frame_valid_q, frame_valid_d;
    logic                       code_err_q, code_err_d;
    logic                       an_err_q, an_err_d;

    logic [3:0] nib;
    logic       hit;
    logic [1:0] k;
    logic       is_idle, is_valid, commit;

    seg7_decode u_dec (
        .pat (seg_q.gfedcba),
        .nib (nib),
        .hit (hit)
    );

    always_comb begin
        k = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (an_q[i]) k = i[1:0];
        is_idle  = (an_q == '0);
        is_valid = $onehot(an_q);

        sh_dig_d      = sh_dig_q;
        sh_dp_d       = sh_dp_q;
        seen_d        = seen_q;
        last_k_d      = last_k_q;
        idle_cnt_d    = idle_cnt_q;
        digits_d      = digits_q;
        dpout_d       = dpout_q;
        en_out_d      = en_out_q;
        frame_valid_d = 1'b0;
        code_err_d    = 1'b0;
        an_err_d      = 1'b0;
        commit        = 1'b0;

        if (is_valid) begin
            // A repeated index also counts as a wrap: the scan has restarted.
            commit = (seen_q != '0) && (k <= last_k_q);
        end else if (is_idle) begin
            if (idle_cnt_q != CW'(IDLE_LIMIT))
                idle_cnt_d = idle_cnt_q + 1'b1;
            commit = (seen_q != '0) && (idle_cnt_d == CW'(IDLE_LIMIT));
        end else begin
            an_err_d = 1'b1;
        end

        if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                digits_d[i] = seen_q[i] ? sh_dig_q[i] : 4'h0;
            dpout_d       = sh_dp_q & seen_q;
            en_out_d      = seen_q;
            frame_valid_d = 1'b1;
            seen_d        = '0;
        end

        // Capture lands in the shadow after any commit has emptied it.
        if (is_valid) begin
            last_k_d   = k;
            idle_cnt_d = '0;
            if (hit) begin
                sh_dig_d[k] = nib;
                sh_dp_d[k]  = seg_q.dp;
                seen_d[k]   = 1'b1;
            end else begin
                code_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            an_q          <= '0;
            seg_q         <= '0;
            sh_dig_q      <= '0;
            sh_dp_q       <= '0;
            seen_q        <= '0;
            last_k_q      <= '0;
            idle_cnt_q    <= '0;
            digits_q      <= '0;
            dpout_q       <= '0;
            en_out_q      <= '0;
            frame_valid_q <= 1'b0;
            code_err_q    <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            an_q          <= bus.an;
            seg_q         <= bus.seg;
            sh_dig_q      <= sh_dig_d;
            sh_dp_q       <= sh_dp_d;
            seen_q        <= seen_d;
            last_k_q      <= last_k_d;
            idle_cnt_q    <= idle_cnt_d;
            digits_q      <= digits_d;
            dpout_q       <= dpout_d;
            en_out_q      <= en_out_d;
            frame_valid_q <= frame_valid_d;
            code_err_q    <= code_err_d;
            an_err_q      <= an_err_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dpout       = dpout_q;
    assign bus.en_out      = en_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.code_err    = code_err_q;
    assign bus.an_err      = an_err_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder: scans, idle commit, errors and reset.
module tb_segment_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   fv_cnt = 0;
    int   ce_cnt = 0;
    int   ae_cnt = 0;

    segment_scan_decoder_if bus();

    segment_scan_decoder #(.IDLE_LIMIT(8)) dut (
        .clk_1kHz (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles, so a stretched pulse counts twice.
    always @(negedge clk) begin
        if (!rst) begin
            fv_cnt += int'(bus.frame_valid);
            ce_cnt += int'(bus.code_err);
            ae_cnt += int'(bus.an_err);
        end
    end

    task automatic step(input logic [3:0] a, input logic [7:0] s);
        @(negedge clk);
        bus.an  = a;
        bus.seg = s;
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 8'h00);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.an  = 4'b0000;
        bus.seg = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic scan4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        step(4'b0001, s0);
        step(4'b0010, s1);
        step(4'b0100, s2);
        step(4'b1000, s3);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.digits !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h exp=0000", bus.digits); end
        total++; if (bus.dpout !== 4'h0) begin bad++; $display("FAIL reset_dpout got=%b exp=0000", bus.dpout); end
        total++; if (bus.en_out !== 4'h0) begin bad++; $display("FAIL reset_en got=%b exp=0000", bus.en_out); end
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
        total++; if (bus.code_err !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b exp=0", bus.code_err); end
        total++; if (bus.an_err !== 1'b0) begin bad++; $display("FAIL reset_ae got=%b exp=0", bus.an_err); end
    endtask

    task automatic test_scan();
        int fv0;
        apply_reset();
        fv0 = fv_cnt;
        scan4(8'h5E, 8'h6F, 8'h5B, 8'h86);
        scan4(8'h5E, 8'h6F, 8'h5B, 8'h86);
        pad(3);
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL scan_fv_count got=%0d exp=1", fv_cnt - fv0); end
        total++; if (bus.digits !== 16'h129D) begin bad++; $display("FAIL scan_digits got=%h exp=129d", bus.digits); end
        total++; if (bus.dpout !== 4'b1000) begin bad++; $display("FAIL scan_dpout got=%b exp=1000", bus.dpout); end
        total++; if (bus.en_out !== 4'b1111) begin bad++; $display("FAIL scan_en got=%b exp=1111", bus.en_out); end
    endtask

    task automatic test_skip_slot();
        int fv0;
        apply_reset();
        fv0 = fv_cnt;
        step(4'b0001, 8'h3F); step(4'b0000, 8'h00); step(4'b0100, 8'h5B); step(4'b1000, 8'h4F);
        step(4'b0001, 8'h3F); step(4'b0000, 8'h00); step(4'b0100, 8'h5B); step(4'b1000, 8'h4F);
        pad(3);
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL skip_fv_count got=%0d exp=1", fv_cnt - fv0); end
        total++; if (bus.en_out !== 4'b1101) begin bad++; $display("FAIL skip_en got=%b exp=1101", bus.en_out); end
        total++; if (bus.digits !== 16'h3200) begin bad++; $display("FAIL skip_digits got=%h exp=3200", bus.digits); end
    endtask

    task automatic test_idle_commit();
        int fv0;
        apply_reset();
        fv0 = fv_cnt;
        step(4'b0001, 8'h6D);
        step(4'b0010, 8'h07);
        pad(8);
        @(posedge clk); #1;
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL idle_early got=%b exp=0", bus.frame_valid); end
        @(posedge clk); #1;
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL idle_commit got=%b exp=1", bus.frame_valid); end
        total++; if (bus.en_out !== 4'b0011) begin bad++; $display("FAIL idle_en got=%b exp=0011", bus.en_out); end
        total++; if (bus.digits !== 16'h0075) begin bad++; $display("FAIL idle_digits got=%h exp=0075", bus.digits); end
        @(posedge clk); #1;
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL idle_pulse_width got=%b exp=0", bus.frame_valid); end
        pad(12);
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL idle_fv_count got=%0d exp=1", fv_cnt - fv0); end
        total++; if (bus.digits !== 16'h0075) begin bad++; $display("FAIL idle_hold got=%h exp=0075", bus.digits); end
    endtask

    task automatic test_code_err();
        int ce0, fv0;
        apply_reset();
        ce0 = ce_cnt;
        fv0 = fv_cnt;
        scan4(8'h3F, 8'h06, 8'h00, 8'h4F);
        scan4(8'h3F, 8'h06, 8'h00, 8'h4F);
        step(4'b0001, 8'h3F);
        pad(3);
        total++; if (ce_cnt - ce0 !== 2) begin bad++; $display("FAIL code_err_count got=%0d exp=2", ce_cnt - ce0); end
        total++; if (fv_cnt - fv0 !== 2) begin bad++; $display("FAIL code_err_fv got=%0d exp=2", fv_cnt - fv0); end
        total++; if (bus.en_out !== 4'b1011) begin bad++; $display("FAIL code_err_en got=%b exp=1011", bus.en_out); end
        total++; if (bus.digits !== 16'h3010) begin bad++; $display("FAIL code_err_digits got=%h exp=3010", bus.digits); end
    endtask

    task automatic test_an_err();
        int ae0, fv0;
        apply_reset();
        ae0 = ae_cnt;
        fv0 = fv_cnt;
        step(4'b0001, 8'h06);
        step(4'b0010, 8'h5B);
        step(4'b0101, 8'h71);
        step(4'b0100, 8'h4F);
        step(4'b1000, 8'h66);
        step(4'b0001, 8'h06);
        pad(3);
        total++; if (ae_cnt - ae0 !== 1) begin bad++; $display("FAIL an_err_count got=%0d exp=1", ae_cnt - ae0); end
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL an_err_fv got=%0d exp=1", fv_cnt - fv0); end
        total++; if (bus.digits !== 16'h4321) begin bad++; $display("FAIL an_err_digits got=%h exp=4321", bus.digits); end
        total++; if (bus.en_out !== 4'b1111) begin bad++; $display("FAIL an_err_en got=%b exp=1111", bus.en_out); end
    endtask

    task automatic test_reset_mid();
        int fv0;
        apply_reset();
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66);
        step(4'b0001, 8'h6D);
        step(4'b0010, 8'h7D);
        step(4'b0100, 8'h07);
        apply_reset();
        total++; if (bus.digits !== 16'h0000) begin bad++; $display("FAIL mid_rst_digits got=%h exp=0000", bus.digits); end
        total++; if (bus.en_out !== 4'b0000) begin bad++; $display("FAIL mid_rst_en got=%b exp=0000", bus.en_out); end
        fv0 = fv_cnt;
        scan4(8'h7F, 8'h6F, 8'h77, 8'h7C);
        pad(3);
        total++; if (fv_cnt - fv0 !== 0) begin bad++; $display("FAIL mid_rst_no_commit got=%0d exp=0", fv_cnt - fv0); end
        step(4'b0001, 8'h7F);
        pad(3);
        total++; if (fv_cnt - fv0 !== 1) begin bad++; $display("FAIL mid_rst_fv got=%0d exp=1", fv_cnt - fv0); end
        total++; if (bus.digits !== 16'hBA98) begin bad++; $display("FAIL mid_rst_digits2 got=%h exp=ba98", bus.digits); end
        total++; if (bus.en_out !== 4'b1111) begin bad++; $display("FAIL mid_rst_en2 got=%b exp=1111", bus.en_out); end
    endtask

    initial begin
        bus.an  = 4'b0000;
        bus.seg = 8'h00;
        test_reset();
        test_scan();
        test_skip_slot();
        test_idle_commit();
        test_code_err();
        test_an_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
